// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: execute-stage sequencer for register-to-register commands.
// Takes one command at a time and steps it through the regfile read ports
// and the external ALU. It then writes the ALU result, or an immediate for
// LDI, back to the regfile.
//
// Command handshake (valid/ready): a command transfers on a rising clk edge
// where cmd_valid and cmd_ready are both high. cmd_ready depends only on the
// FSM state and rst, never on cmd_valid. A producer may hold cmd_valid and
// the command fields steady while cmd_ready is low. Those fields are ignored
// until the transfer edge, when they are latched.
module alu_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_kind,
    input  logic [2:0]        cmd_alu_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rf_w_en,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [ADDR_W-1:0] rf_read_addr1,
    output logic [ADDR_W-1:0] rf_read_addr2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic [DATA_W-1:0] alu_in_b,
    output logic [DATA_W-1:0] alu_in_c,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    output logic [ADDR_W-1:0] res_rd,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              accept;

    // Latched command fields. The kind bit only steers the FSM at accept,
    // so it is not kept.
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;

    // Operands captured at the end of READ, and the value to be written.
    logic [DATA_W-1:0] opnd_b_q;
    logic [DATA_W-1:0] opnd_c_q;
    logic [DATA_W-1:0] result_q;

    // A new command may be taken while idle, or in the WRITE cycle of the
    // previous one so that issue can be back to back.
    assign cmd_ready = ((state == IDLE) || (state == WRITE)) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    // Next-state logic: LDI skips READ/EXEC and goes straight to WRITE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = cmd_kind ? WRITE : READ;
            end
            READ:    state_nxt = EXEC;
            EXEC:    state_nxt = WRITE;
            WRITE: begin
                if (accept) state_nxt = cmd_kind ? WRITE : READ;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register. Reset drops any in-flight command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Command register, loaded on the handshake edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= '0;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
        end else if (accept) begin
            op_q  <= cmd_alu_op;
            rd_q  <= cmd_rd;
            rs1_q <= cmd_rs1;
            rs2_q <= cmd_rs2;
        end
    end

    // Operand capture from the combinational regfile read ports during READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd_b_q <= '0;
            opnd_c_q <= '0;
        end else if (state == READ) begin
            opnd_b_q <= rf_read_data1;
            opnd_c_q <= rf_read_data2;
        end
    end

    // Result register: the immediate on an LDI accept, or the ALU output
    // at the end of EXEC. Both cannot happen in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else if (accept && cmd_kind) begin
            result_q <= cmd_imm;
        end else if (state == EXEC) begin
            result_q <= alu_out;
        end
    end

    // Datapath outputs come straight from registers, so they hold their
    // last value between commands and read as zero under reset.
    assign rf_read_addr1 = rs1_q;
    assign rf_read_addr2 = rs2_q;
    assign alu_in_b      = opnd_b_q;
    assign alu_in_c      = opnd_c_q;
    assign alu_op        = op_q;
    assign rf_write_addr = rd_q;
    assign rf_write_data = result_q;
    assign res_rd        = rd_q;
    assign res_data      = result_q;

    // The write and the result report both happen only in WRITE.
    assign rf_w_en   = (state == WRITE);
    assign res_valid = (state == WRITE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl. It provides a behavioural 8-entry regfile and
// ALU around the controller, drives directed commands, and checks each
// result pulse against hand-computed expected values.
module tb_alu_seq_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int EW     = DATA_W + ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_kind;
  logic [2:0]        cmd_alu_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [DATA_W-1:0] cmd_imm;
  logic              rf_w_en;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic [ADDR_W-1:0] rf_read_addr1;
  logic [ADDR_W-1:0] rf_read_addr2;
  logic [DATA_W-1:0] rf_read_data1;
  logic [DATA_W-1:0] rf_read_data2;
  logic [DATA_W-1:0] alu_in_b;
  logic [DATA_W-1:0] alu_in_c;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_out;
  logic              res_valid;
  logic [ADDR_W-1:0] res_rd;
  logic [DATA_W-1:0] res_data;
  logic              busy;
  logic [1:0]        dbg_state;

  alu_seq_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_kind      (cmd_kind),
    .cmd_alu_op    (cmd_alu_op),
    .cmd_rd        (cmd_rd),
    .cmd_rs1       (cmd_rs1),
    .cmd_rs2       (cmd_rs2),
    .cmd_imm       (cmd_imm),
    .rf_w_en       (rf_w_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .rf_read_addr1 (rf_read_addr1),
    .rf_read_addr2 (rf_read_addr2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2),
    .alu_in_b      (alu_in_b),
    .alu_in_c      (alu_in_c),
    .alu_op        (alu_op),
    .alu_out       (alu_out),
    .res_valid     (res_valid),
    .res_rd        (res_rd),
    .res_data      (res_data),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------- environment: regfile and ALU ----------------
  logic [DATA_W-1:0] rf [8] = '{default: '0};

  always @(posedge clk) begin
    if (rf_w_en) rf[rf_write_addr] <= rf_write_data;
  end

  assign rf_read_data1 = rf[rf_read_addr1];
  assign rf_read_data2 = rf[rf_read_addr2];

  always_comb begin
    alu_out = '0;
    case (alu_op)
      3'd0:    alu_out = alu_in_b + alu_in_c;
      3'd1:    alu_out = alu_in_b - alu_in_c;
      3'd2:    alu_out = alu_in_b & alu_in_c;
      3'd3:    alu_out = alu_in_b | alu_in_c;
      default: alu_out = alu_in_b ^ alu_in_c;
    endcase
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  int            pulse_cyc[$];
  int            pulse_cnt = 0;
  int            wen_cnt   = 0;
  int            cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rf_w_en) wen_cnt++;
    if (res_valid) begin
      pulse_cyc.push_back(cyc);
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        chk("res_rd",   32'(res_rd),        32'(exp_e[EW-1:DATA_W]));
        chk("res_data", 32'(res_data),      32'(exp_e[DATA_W-1:0]));
        chk("wr_addr",  32'(rf_write_addr), 32'(exp_e[EW-1:DATA_W]));
        chk("wr_data",  32'(rf_write_data), 32'(exp_e[DATA_W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic kind, input logic [2:0] op,
                       input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] rs1,
                       input logic [ADDR_W-1:0] rs2, input logic [DATA_W-1:0] imm,
                       output int acc, output int waits);
    @(negedge clk);
    cmd_kind   = kind;
    cmd_alu_op = op;
    cmd_rd     = rd;
    cmd_rs1    = rs1;
    cmd_rs2    = rs2;
    cmd_imm    = imm;
    cmd_valid  = 1'b1;
    waits      = 0;
    while (!cmd_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
    exp_q.push_back({rd, data});
  endtask

  task automatic wait_pulses(input int n);
    int t = 0;
    while (pulse_cnt < n && t < 50) begin
      @(negedge clk);
      t++;
    end
    #1;
    chk("pulse_wait", 32'(pulse_cnt >= n), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  int a0, a1, w, base;

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_kind   = 1'b0;
    cmd_alu_op = '0;
    cmd_rd     = '0;
    cmd_rs1    = '0;
    cmd_rs2    = '0;
    cmd_imm    = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_w_en",      32'(rf_w_en),   32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // LDI r1=2, LDI r2=3 back to back.
    base = wen_cnt;
    issue(1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 8'd2, a0, w);
    push_exp(3'd1, 8'd2);
    issue(1'b1, 3'd0, 3'd2, 3'd0, 3'd0, 8'd3, a1, w);
    push_exp(3'd2, 8'd3);
    wait_pulses(2);
    chk("ldi_latency", 32'(pulse_cyc[0] - a0), 32'd0);
    chk("ldi_b2b",     32'(pulse_cyc[1] - pulse_cyc[0]), 32'd1);
    repeat (2) @(negedge clk);
    chk("ldi_wen_cycles", 32'(wen_cnt - base), 32'd2);
    chk("rf1", 32'(rf[1]), 32'd2);
    chk("rf2", 32'(rf[2]), 32'd3);

    // ADD r3=r1+r2, AND r3=r1&r2, OR r3=r1|r2.
    issue(1'b0, 3'd0, 3'd3, 3'd1, 3'd2, 8'd0, a0, w);
    push_exp(3'd3, 8'd5);
    wait_pulses(3);
    chk("add_latency", 32'(pulse_cyc[2] - a0), 32'd2);
    issue(1'b0, 3'd2, 3'd3, 3'd1, 3'd2, 8'd0, a0, w);
    push_exp(3'd3, 8'd2);
    wait_pulses(4);
    issue(1'b0, 3'd3, 3'd3, 3'd1, 3'd2, 8'd0, a0, w);
    push_exp(3'd3, 8'd3);
    wait_pulses(5);
    @(negedge clk);
    chk("rf3_or", 32'(rf[3]), 32'd3);

    // Dependent back to back: ADD r3=r1+r2, then ADD r4=r3+r3 held during READ/EXEC.
    issue(1'b0, 3'd0, 3'd3, 3'd1, 3'd2, 8'd0, a0, w);
    push_exp(3'd3, 8'd5);
    issue(1'b0, 3'd0, 3'd4, 3'd3, 3'd3, 8'd0, a1, w);
    push_exp(3'd4, 8'd10);
    chk("held_cycles_not_ready", 32'(w), 32'd2);
    wait_pulses(7);
    chk("dep_spacing", 32'(pulse_cyc[6] - pulse_cyc[5]), 32'd3);
    @(negedge clk);
    chk("rf4", 32'(rf[4]), 32'd10);

    // Overflow: 200 + 100 wraps to 44.
    issue(1'b1, 3'd0, 3'd5, 3'd0, 3'd0, 8'd200, a0, w);
    push_exp(3'd5, 8'd200);
    issue(1'b1, 3'd0, 3'd6, 3'd0, 3'd0, 8'd100, a0, w);
    push_exp(3'd6, 8'd100);
    issue(1'b0, 3'd0, 3'd7, 3'd5, 3'd6, 8'd0, a0, w);
    push_exp(3'd7, 8'd44);
    wait_pulses(10);
    @(negedge clk);
    chk("rf7_wrap", 32'(rf[7]), 32'd44);

    // Reset during EXEC of ADD r3=r5+r6: no write, outputs cleared at once.
    issue(1'b0, 3'd0, 3'd3, 3'd5, 3'd6, 8'd0, a0, w);
    @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready",     32'(cmd_ready),     32'd0);
    chk("mid_rst_busy",      32'(busy),          32'd0);
    chk("mid_rst_w_en",      32'(rf_w_en),       32'd0);
    chk("mid_rst_res_valid", 32'(res_valid),     32'd0);
    chk("mid_rst_addr1",     32'(rf_read_addr1), 32'd0);
    chk("mid_rst_addr2",     32'(rf_read_addr2), 32'd0);
    chk("mid_rst_in_b",      32'(alu_in_b),      32'd0);
    chk("mid_rst_in_c",      32'(alu_in_c),      32'd0);
    chk("mid_rst_res_rd",    32'(res_rd),        32'd0);
    chk("mid_rst_res_data",  32'(res_data),      32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rf3_kept", 32'(rf[3]), 32'd5);
    chk("no_dropped_write", 32'(pulse_cnt), 32'd10);

    // Normal operation after release: ADD r0=r1+r2.
    issue(1'b0, 3'd0, 3'd0, 3'd1, 3'd2, 8'd0, a0, w);
    push_exp(3'd0, 8'd5);
    wait_pulses(11);
    chk("post_rst_latency", 32'(pulse_cyc[10] - a0), 32'd2);
    @(negedge clk);
    chk("rf0", 32'(rf[0]), 32'd5);

    repeat (3) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("pulse_total", 32'(pulse_cnt), 32'd11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencing controller that executes register-to-register commands on the shared 8-entry `regfile` and the `alu`. It accepts one command at a time over a valid/ready handshake. For each command it drives the regfile read ports, presents operands and opcode to the ALU, and writes the ALU result (or an immediate) back to the regfile. It replaces hand-timed bench stimulus and is the execute stage for the upcoming instruction front end.

## Interface
Parameters:
- DATA_W, 8, datapath width (regfile word, ALU operands/result)
- ADDR_W, 3, regfile address width (8 registers)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command this cycle
- cmd_kind  in  1  0 = ALU op, 1 = load immediate (LDI)
- cmd_alu_op  in  3  ALU opcode, passed through unmodified (0 add, 2 and, 3 or, others per alu)
- cmd_rd  in  ADDR_W  destination register
- cmd_rs1  in  ADDR_W  source register, ALU operand in_b
- cmd_rs2  in  ADDR_W  source register, ALU operand in_c
- cmd_imm  in  DATA_W  immediate for LDI
- rf_w_en  out  1  regfile write enable
- rf_write_addr  out  ADDR_W  regfile write address
- rf_write_data  out  DATA_W  regfile write data
- rf_read_addr1  out  ADDR_W  regfile read port 1 address
- rf_read_addr2  out  ADDR_W  regfile read port 2 address
- rf_read_data1  in  DATA_W  regfile read port 1 data (combinational read)
- rf_read_data2  in  DATA_W  regfile read port 2 data (combinational read)
- alu_in_b  out  DATA_W  ALU operand b
- alu_in_c  out  DATA_W  ALU operand c
- alu_op  out  3  ALU opcode
- alu_out  in  DATA_W  ALU result (combinational)
- res_valid  out  1  one-cycle pulse, result being written
- res_rd  out  ADDR_W  destination of the reported result
- res_data  out  DATA_W  value being written
- busy  out  1  a command is in flight (state != IDLE)

## Operation
- States: IDLE, READ, EXEC, WRITE.
- cmd_ready = (state is IDLE or WRITE) and not rst. A handshake occurs on a rising edge with cmd_valid and cmd_ready both high. The command fields are latched into an internal command register at that edge.
- On accept: ALU op goes to READ; LDI goes to WRITE with result register = cmd_imm.
- READ: rf_read_addr1/2 = latched rs1/rs2. At the end of the cycle, rf_read_data1/2 are captured into the operand registers. Next state is EXEC.
- EXEC: alu_in_b/alu_in_c = operand registers, alu_op = latched opcode. At the end of the cycle, alu_out is captured into the result register. Next state is WRITE.
- WRITE: rf_w_en = 1, rf_write_addr = res_rd = latched rd, rf_write_data = res_data = result register, res_valid = 1. The write lands at the closing edge. Next state is READ or WRITE if a new command is accepted in this cycle, otherwise IDLE.
- Outside WRITE, rf_w_en = 0 and res_valid = 0. All other outputs hold their last registered value.
- Arithmetic is entirely inside the alu. The controller never modifies data, so results wrap modulo 2^DATA_W.
- rd may equal rs1 or rs2. A source read always sees every previously completed write, because READ of command N+1 follows WRITE of command N by at least one edge.
- Reset (asynchronous, any state, including mid-command): state → IDLE and the in-flight command is dropped with no write. All outputs go to 0 (cmd_ready 0 while rst high, 1 in the first cycle after release). Regfile contents are untouched.

## Timing
- The ALU command is accepted at edge N. READ is the cycle after N, EXEC the cycle after that, and WRITE the third cycle. The regfile is updated at edge N+3.
- The LDI command is accepted at edge N. WRITE is the cycle after N, and the regfile is updated at edge N+1.
- Back-to-back issue (accept during WRITE) gives 3 cycles per ALU command and 1 cycle per LDI.
- cmd_valid high while cmd_ready is low: no accept, and the command inputs are ignored.
- rst is asserted asynchronously and released synchronously to clk.

## Test plan
- LDI r1=2, then LDI r2=3, issued back to back → two consecutive res_valid pulses (rd 1 data 2, rd 2 data 3); rf_w_en high exactly 2 cycles.
- ADD r3=r1+r2 (op 0) → res_valid in the 3rd cycle after accept with rd 3 data 5. Then AND (op 2) r3 → data 2, then OR (op 3) r3 → data 3.
- Dependent back-to-back: ADD r3=r1+r2 with ADD r4=r3+r3 presented during WRITE → second command reads 5 and writes r4=10; 3 cycles between res_valid pulses.
- Overflow: LDI r5=200, LDI r6=100, ADD r7=r5+r6 → res_data 44.
- Hold cmd_valid high with a new command throughout READ/EXEC → cmd_ready low, no accept; the command is accepted in the WRITE cycle.
- Assert rst during EXEC of ADD r3 → all outputs 0 immediately; r3 keeps its old value; the next command after release executes normally.
